imem_loader: RTL
================

# imem_loader

Boot-time instruction-memory loader that sits directly upstream of the single-cycle core's instruction memory. It receives a framed byte stream, assembles big-endian 32-bit instruction words and writes them sequentially from byte address 0. It holds the core halted via `cpu_run` until the image is completely and correctly loaded.

## Interface
Parameters:
- `ADDR_W`, default 8: word-address width; instruction memory depth is 2^ADDR_W words.

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse; begins a load from IDLE, DONE or ERR.
- `byte_valid`  in  1  `byte_data` valid this cycle.
- `byte_data`  in  8  stream byte.
- `byte_ready`  out  1  loader accepts a byte this cycle.
- `mem_we`  out  1  instruction-memory write strobe, one cycle per word.
- `mem_addr`  out  32  byte address, word-aligned (`word_idx << 2`).
- `mem_wdata`  out  32  assembled instruction word.
- `cpu_run`  out  1  core clock-enable / PC-release; high only in DONE.
- `done`  out  1  load completed successfully (level).
- `err`  out  1  load aborted (level).

## Operation
- Frame format: LEN_HI, LEN_LO (16-bit word count N, big-endian), then N×4 data bytes, MSB first.
- A transfer occurs only when `byte_valid && byte_ready`. Bytes offered when `byte_ready`=0 are ignored and not consumed.
- FSM states: IDLE, LEN_HI, LEN_LO, DATA, WRITE, DONE, ERR.
  - IDLE: `start` -> LEN_HI.
  - LEN_HI: on transfer, latch N[15:8] -> LEN_LO.
  - LEN_LO: on transfer, latch N[7:0]. If N=0 -> DONE. If N > 2^ADDR_W -> ERR. Otherwise -> DATA with `word_idx`=0 and byte count=0.
  - DATA: shift each byte into the word register (`{w[23:0],byte}`). On the 4th byte -> WRITE.
  - WRITE: `mem_we`=1 with `mem_addr`=`word_idx<<2` and `mem_wdata`=word. Then `word_idx`++. If `word_idx`=N-1 -> DONE, else -> DATA.
  - DONE / ERR: `start` -> LEN_HI. This clears `done`/`err`, drops `cpu_run` and resets `word_idx`.
- `start` in LEN_HI, LEN_LO, DATA or WRITE is ignored.
- `word_idx` is ADDR_W+1 bits wide, so N = 2^ADDR_W is legal and fills memory exactly. `mem_addr` upper bits are zero.
- `byte_ready` = 1 only in LEN_HI, LEN_LO and DATA (combinational from state).

## Timing
- Reset values: state IDLE, `byte_ready`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `cpu_run`=0, `done`=0, `err`=0.
- `mem_we`, `mem_addr`, `mem_wdata`, `cpu_run`, `done` and `err` are registered.
- `mem_we` is asserted for exactly the one cycle the FSM spends in WRITE. Address and data are stable in that cycle.
- Minimum of 5 cycles per word at full input rate (4 DATA + 1 WRITE). Back-to-back `byte_valid` is stalled during WRITE.
- `cpu_run`/`done` rise the cycle after entering DONE and stay high until `start` or reset.
- Reset asserted mid-load returns to IDLE immediately. Words already written remain in memory; `cpu_run`=0.

## Configuration
- `IMEM_LOADER_CHECKSUM_EN` defined:
  - After the last data byte (or after LEN_LO when N=0), a state CSUM accepts one extra byte.
  - That byte must equal the XOR of all N×4 data bytes. Match -> DONE; mismatch -> ERR. `cpu_run` stays 0 on mismatch.
  - WRITE with `word_idx`=N-1 goes to CSUM instead of DONE, and `byte_ready`=1 in CSUM.
- Not defined: no CSUM state. The frame ends after the last data byte; the next byte is not consumed until a new `start`.

## Test plan
- Reset, `start`, stream 00 02 20 08 00 05 8C 09 00 04 at full rate. Required response:
  - Writes (addr 0x0, 0x20080005) then (0x4, 0x8C090004).
  - `mem_we` high exactly 2 cycles.
  - `done`=`cpu_run`=1 after the last write.
- Same stream with `byte_valid` toggling every other cycle -> identical writes. No byte is lost or duplicated, including bytes offered during WRITE.
- ADDR_W=2, LEN = 00 05 -> ERR the cycle after LEN_LO, no `mem_we`, `cpu_run`=0. Then `start` + LEN 00 00 -> DONE.
- ADDR_W=2, LEN = 00 04 with 16 bytes -> last write at `mem_addr` 0xC, `done`=1.
- Assert `rst_n`=0 after 6 data bytes -> all outputs reach reset values asynchronously. Restart load completes normally.
- With `IMEM_LOADER_CHECKSUM_EN`, frame 00 01 12 34 56 78 plus checksum:
  - Checksum 0x08 -> DONE.
  - Checksum 0x09 -> ERR with `cpu_run`=0; the write to address 0 still occurred.

Source files
------------

// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - byte-stream, instruction-memory write and status bundle for imem_loader
interface imem_loader_if;
  logic        start;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_run;
  logic        done;
  logic        err;

  modport master (
    output start, byte_valid, byte_data,
    input  byte_ready, mem_we, mem_addr, mem_wdata, cpu_run, done, err
  );

  modport slave (
    input  start, byte_valid, byte_data,
    output byte_ready, mem_we, mem_addr, mem_wdata, cpu_run, done, err
  );
endinterface

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - framed byte stream to big-endian instruction words, holds the core until loaded
// Optional trailing XOR checksum byte enabled by IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int ADDR_W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  imem_loader_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_WRITE, S_DONE, S_ERR
`ifdef IMEM_LOADER_CHECKSUM_EN
    , S_CSUM
`endif
  } state_t;

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_t FRAME_END = S_CSUM;
`else
  localparam state_t FRAME_END = S_DONE;
`endif

  localparam logic [16:0]     DEPTH   = 17'(1) << ADDR_W;
  localparam logic [ADDR_W:0] IDX_ONE = (ADDR_W + 1)'(1);

  state_t            state_q, state_d;
  logic [15:0]       len_q, len_d;
  logic [ADDR_W:0]   word_idx_q, word_idx_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [31:0]       word_q, word_d;
  logic              mem_we_q, mem_we_d;
  logic [31:0]       mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic              cpu_run_q, cpu_run_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif

  logic              byte_ready;
  logic              xfer;
  logic [15:0]       len_rx;
  logic              last_word;

  always_comb begin
    byte_ready = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) || (state_q == S_DATA)
`ifdef IMEM_LOADER_CHECKSUM_EN
                 || (state_q == S_CSUM)
`endif
                 ;
  end

  assign xfer      = bus.byte_valid && byte_ready;
  assign len_rx    = {len_q[15:8], bus.byte_data};
  assign last_word = (32'(word_idx_q) == (32'(len_q) - 32'd1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      word_idx_q  <= '0;
      byte_cnt_q  <= '0;
      word_q      <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_run_q   <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      word_idx_q  <= word_idx_d;
      byte_cnt_q  <= byte_cnt_d;
      word_q      <= word_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_run_q   <= cpu_run_d;
      done_q      <= done_d;
      err_q       <= err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: if (bus.start) state_d = S_LEN_HI;
      S_LEN_HI:              if (xfer) state_d = S_LEN_LO;
      S_LEN_LO: begin
        if (xfer) begin
          if (len_rx == 16'd0)              state_d = FRAME_END;
          else if ({1'b0, len_rx} > DEPTH)  state_d = S_ERR;
          else                              state_d = S_DATA;
        end
      end
      S_DATA:                if (xfer && byte_cnt_q == 2'd3) state_d = S_WRITE;
      S_WRITE:               state_d = last_word ? FRAME_END : S_DATA;
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CSUM:                if (xfer) state_d = (bus.byte_data == csum_q) ? S_DONE : S_ERR;
`endif
      default:               state_d = S_IDLE;
    endcase
  end

  always_comb begin
    len_d      = len_q;
    word_idx_d = word_idx_q;
    byte_cnt_d = byte_cnt_q;
    word_d     = word_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_d     = csum_q;
`endif
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (bus.start) begin
          word_idx_d = '0;
          byte_cnt_d = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d     = '0;
`endif
        end
      end
      S_LEN_HI: if (xfer) len_d[15:8] = bus.byte_data;
      S_LEN_LO: begin
        if (xfer) begin
          len_d[7:0] = bus.byte_data;
          word_idx_d = '0;
          byte_cnt_d = '0;
        end
      end
      S_DATA: begin
        if (xfer) begin
          word_d     = {word_q[23:0], bus.byte_data};
          byte_cnt_d = byte_cnt_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d     = csum_q ^ bus.byte_data;
`endif
        end
      end
      S_WRITE:  word_idx_d = word_idx_q + IDX_ONE;
      default:  ;
    endcase
  end

  // Registered outputs are computed from the transition so mem_we coincides with WRITE
  always_comb begin
    mem_we_d    = (state_d == S_WRITE);
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if (state_q == S_DATA && state_d == S_WRITE) begin
      mem_addr_d  = 32'(word_idx_q) << 2;
      mem_wdata_d = word_d;
    end
    done_d    = (state_q == S_DONE) && (state_d == S_DONE);
    cpu_run_d = (state_q == S_DONE) && (state_d == S_DONE);
    err_d     = (state_q == S_ERR)  && (state_d == S_ERR);
  end

  assign bus.byte_ready = byte_ready;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.cpu_run    = cpu_run_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;

endmodule
